pc_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute controller for the 4-bit program counter.

---
 rtl/pc_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute controller driving the program counter, instruction register and execute start.
// Optional return-address stack is built when PC_SEQ_CALL_STACK_EN is defined.
module pc_sequencer #(
    parameter int AW        = 4,
    parameter int CNT_W     = 8,
    parameter int RAS_DEPTH = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             run,
    input  logic             halt_req,
    input  logic [AW-1:0]    pc_cur,
    input  logic             imem_ready,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [AW-1:0]    br_target,
    input  logic             call,
    input  logic             ret,
    output logic             pc_ena,
    output logic             pc_load_en,
    output logic [AW-1:0]    pc_load,
    output logic             ir_we,
    output logic             exec_go,
    output logic             pc_wrap,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             ras_err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                halt_pend_r;
    logic [CNT_W-1:0]    retired_cnt_r;
    logic                commit_s;
    logic                ir_we_s;
    logic                exec_go_s;
    logic                halted_s;
    logic                halt_leave_s;
    logic                load_en_s;
    logic [AW-1:0]       load_val_s;
    logic                wrap_s;

    // State register; clr_n is an active-high asynchronous clear
    always_ff @(posedge clk or posedge clr_n) begin
        if (clr_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and per-state strobes
    always_comb begin
        state_s      = state_r;
        commit_s     = 1'b0;
        ir_we_s      = 1'b0;
        exec_go_s    = 1'b0;
        halted_s     = 1'b0;
        halt_leave_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    ir_we_s = 1'b1;
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                exec_go_s = 1'b1;
                state_s   = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (br_valid) begin
                    commit_s = 1'b1;
                    // a halt request in the commit cycle itself is honoured too
                    if (halt_pend_r || halt_req) begin
                        state_s = ST_HALT;
                    end else if (!run) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_EXECUTE;
                end
            end
            ST_HALT: begin
                halted_s = 1'b1;
                if (run && !halt_req) begin
                    halt_leave_s = 1'b1;
                    state_s      = ST_FETCH;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sticky halt request, dropped when HALT is left
    always_ff @(posedge clk or posedge clr_n) begin
        if (clr_n) begin
            halt_pend_r <= 1'b0;
        end else if (halt_leave_s) begin
            halt_pend_r <= 1'b0;
        end else if (halt_req) begin
            halt_pend_r <= 1'b1;
        end else begin
            halt_pend_r <= halt_pend_r;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge clr_n) begin
        if (clr_n) begin
            retired_cnt_r <= {CNT_W{1'b0}};
        end else if (commit_s) begin
            retired_cnt_r <= retired_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_cnt_r <= retired_cnt_r;
        end
    end

`ifdef PC_SEQ_CALL_STACK_EN
    localparam int RC_W = $clog2(RAS_DEPTH + 1);

    logic [AW-1:0]   ras_r [RAS_DEPTH];
    logic [RC_W-1:0] ras_cnt_r;
    logic            ras_err_r;
    logic            pop_s;
    logic            push_s;
    logic [AW-1:0]   ras_top_s;

    // ret has priority over call when both are flagged
    always_comb begin
        pop_s     = commit_s && ret;
        push_s    = commit_s && call && !ret;
        ras_top_s = {AW{1'b0}};
        if (ras_cnt_r != {RC_W{1'b0}}) begin
            ras_top_s = ras_r[0];
        end else begin
            ras_top_s = {AW{1'b0}};
        end
    end

    // Return-address stack: entry 0 is the top, oldest entry falls off the bottom
    always_ff @(posedge clk or posedge clr_n) begin
        if (clr_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_r[i] <= {AW{1'b0}};
            end
            ras_cnt_r <= {RC_W{1'b0}};
            ras_err_r <= 1'b0;
        end else if (pop_s) begin
            for (int i = 0; i < RAS_DEPTH - 1; i++) begin
                ras_r[i] <= ras_r[i+1];
            end
            ras_r[RAS_DEPTH-1] <= {AW{1'b0}};
            if (ras_cnt_r == {RC_W{1'b0}}) begin
                ras_err_r <= 1'b1;
            end else begin
                ras_cnt_r <= ras_cnt_r - {{(RC_W-1){1'b0}}, 1'b1};
                ras_err_r <= ras_err_r | call;
            end
        end else if (push_s) begin
            ras_r[0] <= pc_cur + {{(AW-1){1'b0}}, 1'b1};
            for (int i = 1; i < RAS_DEPTH; i++) begin
                ras_r[i] <= ras_r[i-1];
            end
            if (ras_cnt_r == RC_W'(RAS_DEPTH)) begin
                ras_err_r <= 1'b1;
            end else begin
                ras_cnt_r <= ras_cnt_r + {{(RC_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ras_cnt_r <= ras_cnt_r;
            ras_err_r <= ras_err_r;
        end
    end

    // Commit load select including call/return
    always_comb begin
        load_en_s  = 1'b0;
        load_val_s = {AW{1'b0}};
        if (commit_s) begin
            load_en_s = br_taken | call | ret;
            if (ret) begin
                load_val_s = ras_top_s;
            end else begin
                load_val_s = br_target;
            end
        end else begin
            load_en_s  = 1'b0;
            load_val_s = {AW{1'b0}};
        end
    end

    assign ras_err = ras_err_r;
`else
    wire unused_callret_s = &{1'b0, call, ret, RAS_DEPTH[0]};

    // Commit load select, branch only
    always_comb begin
        load_en_s  = 1'b0;
        load_val_s = {AW{1'b0}};
        if (commit_s) begin
            load_en_s  = br_taken;
            load_val_s = br_target;
        end else begin
            load_en_s  = 1'b0;
            load_val_s = {AW{1'b0}};
        end
    end

    assign ras_err = 1'b0;
`endif

    assign wrap_s      = commit_s && !load_en_s && (pc_cur == {AW{1'b1}});
    assign pc_ena      = commit_s;
    assign pc_load_en  = load_en_s;
    assign pc_load     = load_val_s;
    assign ir_we       = ir_we_s;
    assign exec_go     = exec_go_s;
    assign pc_wrap     = wrap_s;
    assign halted      = halted_s;
    assign retired_cnt = retired_cnt_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected output vectors are queued per cycle and compared at the falling edge.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       run;
    logic       halt_req;
    logic [3:0] pc_cur;
    logic       imem_ready;
    logic       br_valid;
    logic       br_taken;
    logic [3:0] br_target;
    logic       call;
    logic       ret;
    logic       pc_ena;
    logic       pc_load_en;
    logic [3:0] pc_load;
    logic       ir_we;
    logic       exec_go;
    logic       pc_wrap;
    logic       halted;
    logic [7:0] retired_cnt;
    logic       ras_err;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic        exp_err      = 1'b0;
    logic [18:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    pc_sequencer #(.AW(4), .CNT_W(8), .RAS_DEPTH(2)) dut (
        .clk(clk), .clr_n(clr_n), .run(run), .halt_req(halt_req), .pc_cur(pc_cur),
        .imem_ready(imem_ready), .br_valid(br_valid), .br_taken(br_taken),
        .br_target(br_target), .call(call), .ret(ret), .pc_ena(pc_ena),
        .pc_load_en(pc_load_en), .pc_load(pc_load), .ir_we(ir_we), .exec_go(exec_go),
        .pc_wrap(pc_wrap), .halted(halted), .retired_cnt(retired_cnt), .ras_err(ras_err)
    );

    function automatic logic [18:0] ev(input logic pe, input logic le, input logic [3:0] pl,
                                       input logic iw, input logic eg, input logic wr,
                                       input logic ht, input logic [7:0] cnt, input logic er);
        return {pe, le, pl, iw, eg, wr, ht, cnt, er};
    endfunction

    function automatic logic [18:0] obs();
        return {pc_ena, pc_load_en, pc_load, ir_we, exec_go, pc_wrap, halted, retired_cnt, ras_err};
    endfunction

    function automatic logic [18:0] z(input logic [7:0] cnt);
        return ev(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, cnt, exp_err);
    endfunction
    function automatic logic [18:0] f(input logic [7:0] cnt);
        return ev(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, cnt, exp_err);
    endfunction
    function automatic logic [18:0] d(input logic [7:0] cnt);
        return ev(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, cnt, exp_err);
    endfunction
    function automatic logic [18:0] x(input logic le, input logic [3:0] pl, input logic wr,
                                      input logic [7:0] cnt);
        return ev(1'b1, le, pl, 1'b0, 1'b0, wr, 1'b0, cnt, exp_err);
    endfunction
    function automatic logic [18:0] h(input logic [7:0] cnt);
        return ev(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, cnt, exp_err);
    endfunction

    task automatic compare_front();
        logic [18:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        tests_run++;
        assert (obs() === e) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", t, obs(), e);
        end
    endtask

    task automatic cyc(input string t, input logic [18:0] e);
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        compare_front();
        @(posedge clk);
        #1;
    endtask

    task automatic now(input string t, input logic [18:0] e);
        exp_q.push_back(e);
        tag_q.push_back(t);
        compare_front();
    endtask

    initial begin
        clr_n = 1'b1; run = 1'b0; halt_req = 1'b0; pc_cur = 4'h0; imem_ready = 1'b0;
        br_valid = 1'b0; br_taken = 1'b0; br_target = 4'h0; call = 1'b0; ret = 1'b0;
        @(posedge clk);
        #1;
        now("reset", z(8'd0));
        @(negedge clk);
        clr_n = 1'b0;
        @(posedge clk);
        #1;

        // sequential run, 3 cycles per instruction
        run = 1'b1; imem_ready = 1'b1; br_valid = 1'b1;
        cyc("idle", z(8'd0));
        for (int k = 0; k < 3; k++) begin
            cyc("seq_fetch", f(8'(k)));
            cyc("seq_decode", d(8'(k)));
            cyc("seq_commit", x(1'b0, 4'h0, 1'b0, 8'(k)));
        end

        // taken branch
        cyc("br_fetch", f(8'd3));
        cyc("br_decode", d(8'd3));
        br_taken = 1'b1; br_target = 4'hA;
        cyc("br_commit", x(1'b1, 4'hA, 1'b0, 8'd3));
        br_taken = 1'b0; br_target = 4'h0;

        // halt request during a stalled fetch
        imem_ready = 1'b0; halt_req = 1'b1;
        cyc("halt_req_fetch", z(8'd4));
        halt_req = 1'b0;
        for (int k = 0; k < 3; k++) cyc("fetch_stall", z(8'd4));
        imem_ready = 1'b1;
        cyc("halt_fetch", f(8'd4));
        cyc("halt_decode", d(8'd4));
        run = 1'b0;
        cyc("halt_commit", x(1'b0, 4'h0, 1'b0, 8'd4));
        cyc("halted_1", h(8'd5));
        cyc("halted_2", h(8'd5));
        run = 1'b1;
        cyc("halted_leave", h(8'd5));
        cyc("resume_fetch", f(8'd5));
        cyc("resume_decode", d(8'd5));
        cyc("resume_commit", x(1'b0, 4'h0, 1'b0, 8'd5));

        // pc wrap and counter roll-over
        pc_cur = 4'hF;
        for (int c = 6; c <= 255; c++) begin
            cyc("wrap_fetch", f(8'(c)));
            cyc("wrap_decode", d(8'(c)));
            cyc("wrap_commit", x(1'b0, 4'h0, 1'b1, 8'(c)));
        end
        cyc("cnt_rollover", f(8'd0));
        cyc("self_decode", d(8'd0));
        br_taken = 1'b1; br_target = 4'hF;
        cyc("branch_to_self", x(1'b1, 4'hF, 1'b0, 8'd0));
        br_taken = 1'b0; br_target = 4'h0; pc_cur = 4'h0;

        // reset while in EXECUTE
        cyc("rst_fetch", f(8'd1));
        br_valid = 1'b0;
        cyc("rst_decode", d(8'd1));
        cyc("exec_wait", z(8'd1));
        br_valid = 1'b1;
        #1;
        now("commit_visible", x(1'b0, 4'h0, 1'b0, 8'd1));
        clr_n = 1'b1;
        #1;
        now("async_clear", z(8'd0));
        @(negedge clk);
        run = 1'b0;
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        cyc("post_reset_idle", z(8'd0));

`ifdef PC_SEQ_CALL_STACK_EN
        run = 1'b1; pc_cur = 4'h3; br_target = 4'h8; call = 1'b1;
        cyc("ras_idle", z(8'd0));
        cyc("call_fetch", f(8'd0));
        cyc("call_decode", d(8'd0));
        cyc("call_commit", x(1'b1, 4'h8, 1'b0, 8'd0));
        call = 1'b0; ret = 1'b1; pc_cur = 4'h8;
        cyc("ret_fetch", f(8'd1));
        cyc("ret_decode", d(8'd1));
        cyc("ret_commit", x(1'b1, 4'h4, 1'b0, 8'd1));
        ret = 1'b0; call = 1'b1; pc_cur = 4'h5; br_target = 4'h2;
        for (int k = 0; k < 3; k++) begin
            cyc("nest_fetch", f(8'(2 + k)));
            cyc("nest_decode", d(8'(2 + k)));
            cyc("nest_commit", x(1'b1, 4'h2, 1'b0, 8'(2 + k)));
        end
        exp_err = 1'b1;
        cyc("ras_overflow", f(8'd5));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
